// File: rtl/uart_tx_fifo_if.sv
// Byte handshake bundle between the MMIO UART write port and the UART transmitter's stream input.
// The slave modport is the FIFO, which takes the push side and presents the head byte.
interface uart_tx_fifo_if;
  logic [7:0] wr_data;
  logic       wr_en;
  logic [7:0] data;
  logic       valid;
  logic       out_ready;

  modport master (output wr_data, output wr_en, output out_ready,
                  input  data,    input  valid);
  modport slave  (input  wr_data, input  wr_en, input  out_ready,
                  output data,    output valid);
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the UART transmitter; the head byte is visible one cycle after its push.
// Pushes into a full FIFO are dropped and latched in a sticky overflow flag, unless a pop frees a slot in the same cycle.
module uart_tx_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_en,
  uart_tx_fifo_if.slave     bus,
  input  logic              i_clear_overflow,
  output logic [ADDR_W:0]   o_count,
  output logic              o_full,
  output logic              o_empty,
  output logic              o_overflow
);
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  logic [7:0]        mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              pop, push_req, push, drop;

  always_comb begin
    pop      = clk_en & (count_q != '0) & bus.out_ready;
    push_req = clk_en & bus.wr_en;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    push     = push_req & ((count_q != FULL_CNT) | pop);
    drop     = push_req & (count_q == FULL_CNT) & ~pop;

    wr_ptr_d = push ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;

    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (ADDR_W+1)'(1);
      2'b01:   count_d = count_q - (ADDR_W+1)'(1);
      default: count_d = count_q;
    endcase

    ovf_d = ovf_q;
    if (drop)
      ovf_d = 1'b1;
    else if (clk_en & i_clear_overflow)
      ovf_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage is left uninitialised on reset; count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (rst && push)
      mem_q[wr_ptr_q] <= bus.wr_data;
  end

  assign bus.data   = mem_q[rd_ptr_q];
  assign bus.valid  = (count_q != '0);
  assign o_count    = count_q;
  assign o_full     = (count_q == FULL_CNT);
  assign o_empty    = (count_q == '0);
  assign o_overflow = ovf_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomised and directed bench for uart_tx_fifo with a queue-based reference model and decoupled scoreboard monitor.
module tb_uart_tx_fifo;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            clk_en;
  logic            i_clear_overflow;
  logic [ADDR_W:0] o_count;
  logic            o_full, o_empty, o_overflow;

  uart_tx_fifo_if bus ();

  uart_tx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk              (clk),
    .rst              (rst),
    .clk_en           (clk_en),
    .bus              (bus),
    .i_clear_overflow (i_clear_overflow),
    .o_count          (o_count),
    .o_full           (o_full),
    .o_empty          (o_empty),
    .o_overflow       (o_overflow)
  );

  always #5 clk = ~clk;

  int         errors = 0;
  int         checks = 0;
  logic [7:0] sb[$];
  int         m_count = 0;
  logic       m_ovf = 1'b0;
  logic       chk_on = 1'b0;
  logic [7:0] last_pop = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a byte queue plus occupancy/overflow rules, evaluated at each active edge.
  always @(posedge clk) begin
    if (!rst) begin
      sb.delete();
      m_count = 0;
      m_ovf   = 1'b0;
      chk_on  = 1'b1;
    end else if (clk_en) begin
      automatic bit p_pop = bus.out_ready && (m_count > 0);
      automatic bit drop  = 1'b0;
      if (bus.wr_en) begin
        if (m_count < DEPTH || p_pop) begin
          sb.push_back(bus.wr_data);
          m_count++;
        end else begin
          drop = 1'b1;
        end
      end
      if (p_pop) m_count--;
      if (drop) m_ovf = 1'b1;
      else if (i_clear_overflow) m_ovf = 1'b0;
    end
  end

  // Monitor: checks status every cycle and consumes expected bytes as the DUT hands them out.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("count", 32'(o_count), 32'(m_count));
      chk("full", 32'(o_full), 32'(m_count == DEPTH));
      chk("empty", 32'(o_empty), 32'(m_count == 0));
      chk("valid", 32'(bus.valid), 32'(m_count != 0));
      chk("overflow", 32'(o_overflow), 32'(m_ovf));
      if (bus.valid === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL data: got %0h with valid high, expected no byte at %0t", bus.data, $time);
        end else begin
          chk("data", 32'(bus.data), 32'(sb[0]));
          if (clk_en && bus.out_ready && rst)
            last_pop = sb.pop_front();
        end
      end
    end
  end

  task automatic drive(input logic r, input logic e, input logic w, input logic [7:0] d,
                       input logic rd, input logic cl);
    rst = r; clk_en = e; bus.wr_en = w; bus.wr_data = d;
    bus.out_ready = rd; i_clear_overflow = cl;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 4 * DEPTH && o_empty !== 1'b1; k++)
      drive(1, 1, 0, 8'h00, 1, 0);
    chk(name, 32'(o_empty), 32'd1);
  endtask

  initial begin
    // Reset held with a pending write: nothing may be captured.
    drive(0, 1, 1, 8'h41, 0, 0);
    drive(0, 1, 1, 8'h41, 0, 0);
    chk("rst_valid", 32'(bus.valid), 32'd0);
    chk("rst_count", 32'(o_count), 32'd0);
    drive(1, 1, 0, 8'h00, 1, 0);
    chk("rst_no_byte", 32'(o_empty), 32'd1);

    drive(1, 1, 1, 8'h48, 0, 0);
    chk("single_data", 32'(bus.data), 32'h48);
    for (int i = 0; i < 5; i++) drive(1, 1, 0, 8'h00, 0, 0);
    chk("single_hold", 32'(bus.data), 32'h48);
    drive(1, 1, 0, 8'h00, 1, 0);
    chk("single_pop", 32'(o_empty), 32'd1);

    for (int i = 0; i < DEPTH; i++) drive(1, 1, 1, 8'(i), 0, 0);
    chk("burst_full", 32'(o_full), 32'd1);
    chk("burst_count", 32'(o_count), 32'd16);
    drive(1, 1, 1, 8'h99, 0, 0);
    chk("drop_ovf", 32'(o_overflow), 32'd1);
    chk("drop_count", 32'(o_count), 32'd16);
    drive(1, 1, 0, 8'h00, 0, 1);
    chk("clear_ovf", 32'(o_overflow), 32'd0);
    drive(1, 1, 1, 8'h99, 0, 1);
    chk("clear_and_drop", 32'(o_overflow), 32'd1);
    drive(1, 1, 0, 8'h00, 0, 1);
    drive(1, 1, 1, 8'h7E, 1, 0);
    chk("full_pushpop_count", 32'(o_count), 32'd16);
    chk("full_pushpop_ovf", 32'(o_overflow), 32'd0);
    drain("drain_full");
    chk("last_7e", 32'(last_pop), 32'h7E);

    for (int i = 0; i < 10; i++) drive(1, 1, 1, 8'(8'h30 + i), 0, 0);
    for (int i = 0; i < 24; i++)
      drive(1, 1, 1'($urandom_range(0, 3) != 0), 8'(8'h50 + i), 1'($urandom_range(0, 1)), 0);
    drain("drain_wrap");

    drive(1, 1, 1, 8'hA1, 0, 0);
    drive(1, 1, 1, 8'hA2, 0, 0);
    drive(1, 1, 1, 8'hA3, 0, 0);
    for (int i = 0; i < 4; i++) drive(1, 0, 1, 8'h55, 1, 1);
    chk("gate_count", 32'(o_count), 32'd3);
    chk("gate_data", 32'(bus.data), 32'hA1);
    drain("drain_gate");
    chk("gate_last", 32'(last_pop), 32'hA3);

    for (int i = 0; i < 800; i++)
      drive(1'($urandom_range(0, 199) != 0), 1'($urandom_range(0, 7) != 0),
            1'($urandom_range(0, 2) != 0), 8'($urandom), 1'($urandom_range(0, 2) == 0),
            1'($urandom_range(0, 15) == 0));
    drain("drain_random");
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
